// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the PC-stage state type.
package cpu_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned WORD_SHIFT  = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pc_state_e;

endpackage : cpu_pkg

// File: rtl/pc_branch_unit_if.sv
// Branch-control inputs and PC-stage outputs between decode/ALU and the PC unit.
interface pc_branch_unit_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned CNT_W = 16
);

  logic             STALL;
  logic             VALID;
  logic             J;
  logic             BEQ;
  logic             BNE;
  logic             BLT;
  logic             ZERO;
  logic             NEG;
  logic [OFF_W-1:0] OFFSET;

  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  PC_INC;
  logic             TAKEN;
  logic             FLUSH;
  logic             REDIRECT_PENDING;
  logic [CNT_W-1:0] TAKEN_COUNT;

  modport master (
    output STALL, VALID, J, BEQ, BNE, BLT, ZERO, NEG, OFFSET,
    input  PC, PC_INC, TAKEN, FLUSH, REDIRECT_PENDING, TAKEN_COUNT
  );

  modport slave (
    input  STALL, VALID, J, BEQ, BNE, BLT, ZERO, NEG, OFFSET,
    output PC, PC_INC, TAKEN, FLUSH, REDIRECT_PENDING, TAKEN_COUNT
  );

endinterface : pc_branch_unit_if

// File: rtl/branch_offset_gen.sv
// Turns a signed instruction-count offset into a PC_W-wide byte offset.
module branch_offset_gen
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OFF_W = 8
) (
  input  logic [OFF_W-1:0] offset_i,
  output logic [PC_W-1:0]  byte_off_c_o
);

  logic [PC_W-1:0] sext_c;

  assign sext_c       = {{(PC_W - OFF_W){offset_i[OFF_W-1]}}, offset_i};
  assign byte_off_c_o = sext_c << WORD_SHIFT;

endmodule : branch_offset_gen

// File: rtl/pc_branch_unit.sv
// Registered PC stage: branch resolution, stall-held redirect, flush pulse, taken counter.
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     OFF_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input logic              CLK,
  input logic              RESET,
  pc_branch_unit_if.slave  bus
);

  pc_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pend_q, pend_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]  byte_off_c;
  logic [PC_W-1:0]  seq_pc_c;
  logic [PC_W-1:0]  target_c;
  logic             take_c;

  branch_offset_gen #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_off (
    .offset_i     (bus.OFFSET),
    .byte_off_c_o (byte_off_c)
  );

  // Branch decision is masked while a redirect is already parked.
  assign take_c   = (state_q == IDLE) & bus.VALID &
                    (bus.J | (bus.BEQ & bus.ZERO) | (bus.BNE & ~bus.ZERO) | (bus.BLT & bus.NEG));
  assign seq_pc_c = pc_q + PC_W'(INSTR_BYTES);
  assign target_c = seq_pc_c + byte_off_c;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Count at acceptance so a parked redirect is never counted twice.
        if (take_c && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!bus.STALL) begin
          pc_d    = take_c ? target_c : seq_pc_c;
          flush_d = take_c;
        end else if (take_c) begin
          pend_d  = target_c;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (!bus.STALL) begin
          pc_d    = pend_q;
          flush_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PC               = pc_q;
  assign bus.PC_INC           = take_c ? byte_off_c : '0;
  assign bus.TAKEN            = take_c;
  assign bus.FLUSH            = flush_q;
  assign bus.REDIRECT_PENDING = (state_q == PENDING);
  assign bus.TAKEN_COUNT      = cnt_q;

endmodule : pc_branch_unit

// File: tb/tb_pc_branch_unit.sv
// Directed and random stimulus for pc_branch_unit against a behavioural PC model.
module tb_pc_branch_unit;

  logic CLK;
  logic RESET;

  pc_branch_unit_if #(.PC_W(32), .OFF_W(8), .CNT_W(16)) bus  ();
  pc_branch_unit_if #(.PC_W(32), .OFF_W(8), .CNT_W(2))  bus2 ();

  pc_branch_unit #(.PC_W(32), .OFF_W(8), .RESET_PC(32'h100), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  pc_branch_unit #(.PC_W(32), .OFF_W(8), .RESET_PC(32'h100), .CNT_W(2)) dut2 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus variables
  logic       i_rst, i_stall, i_valid, i_j, i_beq, i_bne, i_blt, i_zero, i_neg;
  logic [7:0] i_off;

  // Reference model state
  logic [31:0] m_pc, m_ptgt;
  bit          m_pend, m_flush;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_take();
    return !m_pend && i_valid &&
           (i_j || (i_beq && i_zero) || (i_bne && !i_zero) || (i_blt && i_neg));
  endfunction

  function automatic logic [31:0] m_byte_off();
    int w;
    w = int'($signed(i_off));
    return 32'(w * 4);
  endfunction

  function automatic logic [63:0] sat(input int unsigned v, input int unsigned max);
    return 64'((v > max) ? max : v);
  endfunction

  task automatic set_in(input logic v, input logic j, input logic beq, input logic bne,
                        input logic blt, input logic z, input logic n, input logic [7:0] off,
                        input logic st);
    i_valid = v; i_j = j; i_beq = beq; i_bne = bne; i_blt = blt;
    i_zero = z; i_neg = n; i_off = off; i_stall = st;
  endtask

  task automatic apply();
    RESET       = i_rst;
    bus.STALL   = i_stall; bus2.STALL  = i_stall;
    bus.VALID   = i_valid; bus2.VALID  = i_valid;
    bus.J       = i_j;     bus2.J      = i_j;
    bus.BEQ     = i_beq;   bus2.BEQ    = i_beq;
    bus.BNE     = i_bne;   bus2.BNE    = i_bne;
    bus.BLT     = i_blt;   bus2.BLT    = i_blt;
    bus.ZERO    = i_zero;  bus2.ZERO   = i_zero;
    bus.NEG     = i_neg;   bus2.NEG    = i_neg;
    bus.OFFSET  = i_off;   bus2.OFFSET = i_off;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    bit          tk;
    logic [31:0] tgt;
    apply();
    #1;
    tk  = m_take();
    tgt = m_pc + 32'd4 + m_byte_off();
    chk("taken", 64'(bus.TAKEN), 64'(tk));
    chk("pc_inc", 64'(bus.PC_INC), 64'(tk ? m_byte_off() : 32'd0));
    if (!i_rst) begin
      m_pc = 32'h100; m_pend = 0; m_ptgt = '0; m_flush = 0; m_cnt = 0;
    end else if (m_pend) begin
      m_flush = 0;
      if (!i_stall) begin
        m_pc = m_ptgt; m_flush = 1; m_pend = 0;
      end
    end else begin
      if (tk) m_cnt++;
      m_flush = 0;
      if (!i_stall) begin
        m_pc    = tk ? tgt : m_pc + 32'd4;
        m_flush = tk;
      end else if (tk) begin
        m_pend = 1; m_ptgt = tgt;
      end
    end
    @(posedge CLK);
    #1;
    chk("pc", 64'(bus.PC), 64'(m_pc));
    chk("flush", 64'(bus.FLUSH), 64'(m_flush));
    chk("pending", 64'(bus.REDIRECT_PENDING), 64'(m_pend));
    chk("count16", 64'(bus.TAKEN_COUNT), sat(m_cnt, 65535));
    chk("count2", 64'(bus2.TAKEN_COUNT), sat(m_cnt, 3));
  endtask

  task automatic jump_to(input logic [31:0] target);
    int d;
    d = int'(target - m_pc - 32'd4);
    set_in(1, 1, 0, 0, 0, 0, 0, 8'(d >>> 2), 0);
    tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    tick();
    i_rst = 1'b1;
  endtask

  initial begin
    int unsigned c0;
    i_rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    apply();
    @(posedge CLK);
    #1;
    m_pc = 32'h100; m_pend = 0; m_ptgt = '0; m_flush = 0; m_cnt = 0;

    // Reset held a second cycle, then three plain cycles
    tick();
    chk("rst_pc", 64'(bus.PC), 64'h100);
    chk("rst_flush", 64'(bus.FLUSH), 64'h0);
    chk("rst_pend", 64'(bus.REDIRECT_PENDING), 64'h0);
    chk("rst_cnt", 64'(bus.TAKEN_COUNT), 64'h0);
    i_rst = 1'b1;
    tick(); chk("seq1", 64'(bus.PC), 64'h104);
    tick(); chk("seq2", 64'(bus.PC), 64'h108);
    tick(); chk("seq3", 64'(bus.PC), 64'h10C);

    // BEQ taken from 0x40
    jump_to(32'h40);
    set_in(1, 0, 1, 0, 0, 1, 0, 8'hFE, 0);
    apply(); #1;
    chk("beq_taken", 64'(bus.TAKEN), 64'h1);
    chk("beq_inc", 64'(bus.PC_INC), 64'hFFFF_FFF8);
    tick();
    chk("beq_pc", 64'(bus.PC), 64'h3C);
    chk("beq_flush", 64'(bus.FLUSH), 64'h1);
    // BEQ not taken from 0x40
    jump_to(32'h40);
    set_in(1, 0, 1, 0, 0, 0, 0, 8'hFE, 0);
    tick();
    chk("beqn_pc", 64'(bus.PC), 64'h44);
    chk("beqn_flush", 64'(bus.FLUSH), 64'h0);

    // BNE then BLT taken
    jump_to(32'h20);
    c0 = m_cnt;
    set_in(1, 0, 0, 1, 0, 0, 0, 8'd3, 0);
    tick();
    chk("bne_pc", 64'(bus.PC), 64'h30);
    set_in(1, 0, 0, 0, 1, 0, 1, 8'd1, 0);
    tick();
    chk("blt_pc", 64'(bus.PC), 64'h38);
    chk("bnblt_cnt", 64'(bus.TAKEN_COUNT), 64'(c0 + 2));

    // Redirect held across a stall
    jump_to(32'h80);
    c0 = m_cnt;
    set_in(1, 1, 0, 0, 0, 0, 0, 8'd4, 1);
    tick();
    set_in(1, 0, 1, 0, 0, 1, 0, 8'h10, 1); tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h7F, 1); tick();
    chk("stall_pc", 64'(bus.PC), 64'h80);
    chk("stall_pend", 64'(bus.REDIRECT_PENDING), 64'h1);
    chk("stall_cnt", 64'(bus.TAKEN_COUNT), 64'(c0 + 1));
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h7F, 0);
    tick();
    chk("rel_pc", 64'(bus.PC), 64'h94);
    chk("rel_flush", 64'(bus.FLUSH), 64'h1);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    tick();
    chk("rel_flush_off", 64'(bus.FLUSH), 64'h0);

    // Address wrap, then reset while a redirect is parked
    jump_to(32'h10);
    jump_to(32'hFFFF_FFF8);
    set_in(1, 1, 0, 0, 0, 0, 0, 8'd1, 0);
    tick();
    chk("wrap_pc", 64'(bus.PC), 64'h0);
    set_in(1, 1, 0, 0, 0, 0, 0, 8'd5, 1);
    tick();
    chk("pend_set", 64'(bus.REDIRECT_PENDING), 64'h1);
    i_rst = 1'b0;
    tick();
    chk("mid_rst_pc", 64'(bus.PC), 64'h100);
    chk("mid_rst_pend", 64'(bus.REDIRECT_PENDING), 64'h0);
    i_rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    tick();
    chk("mid_rst_noflush", 64'(bus.FLUSH), 64'h0);
    chk("mid_rst_seq", 64'(bus.PC), 64'h104);

    // Saturation of the 2-bit counter
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 8'h00, 0);
      tick();
      chk("sat2", 64'(bus2.TAKEN_COUNT), 64'((k > 3) ? 3 : k));
    end

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      i_rst = ($urandom_range(0, 59) != 0);
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
             1'($urandom % 2), 1'($urandom % 2), 8'($urandom),
             1'($urandom_range(0, 2) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_branch_unit

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter unit for the CPU datapath, generalising the earlier fixed-width jump/branch offset gate into a parametrised, registered PC stage. It evaluates J/BEQ/BNE/BLT against the ALU flags, forms the byte offset and target address, and owns the PC register. It also holds a redirect that resolves during a pipeline stall, reports a one-cycle flush, and keeps a saturating taken-branch count.

## Interface
- PC_W, 32, PC and target width in bits
- OFF_W, 8, width of the signed word offset field from the instruction
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, taken-branch counter width
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- STALL  in  1  pipeline stall; PC must not advance while high
- VALID  in  1  decode holds a valid instruction this cycle
- J, BEQ, BNE, BLT  in  1 each  control-unit branch-kind strobes
- ZERO, NEG  in  1 each  ALU result flags for the current branch compare
- OFFSET  in  OFF_W  signed offset in instructions, relative to PC+4
- PC  out  PC_W  current program counter
- PC_INC  out  PC_W  gated byte offset: sext(OFFSET)<<2 when taken, else 0
- TAKEN  out  1  branch/jump taken this cycle (combinational)
- FLUSH  out  1  registered one-cycle pulse: PC has just been redirected
- REDIRECT_PENDING  out  1  a taken redirect is held awaiting stall release
- TAKEN_COUNT  out  CNT_W  saturating count of accepted taken redirects

## Operation
- take = VALID & (J | (BEQ & ZERO) | (BNE & ~ZERO) | (BLT & NEG)) while in IDLE; forced 0 in PENDING.
- Multiple strobes together are legal: terms are ORed.
- Offset: sign-extend OFFSET to PC_W, shift left 2, truncate to PC_W.
- Target = PC + 4 + offset, modulo 2^PC_W. Wrap-around is silent.
- PC_INC = take ? offset : 0. TAKEN = take.
- States: IDLE, PENDING.
  - IDLE, STALL=0: PC <= take ? target : PC+4. FLUSH <= take.
  - IDLE, STALL=1, take=0: PC holds. FLUSH <= 0.
  - IDLE, STALL=1, take=1: PC holds. pend_target <= target. Go to PENDING. FLUSH <= 0.
  - PENDING, STALL=1: hold everything. Branch inputs are ignored.
  - PENDING, STALL=0: PC <= pend_target. FLUSH <= 1. Go to IDLE. Branch inputs are ignored this cycle.
- Counter:
  - Increments when a redirect is accepted: IDLE & take, regardless of STALL.
  - A redirect is counted once, not again when applied from PENDING.
  - Saturates at all-ones.
- REDIRECT_PENDING = (state == PENDING).
- Reset (RESET=0 at an edge, any state, including mid-PENDING):
  - PC = RESET_PC.
  - State IDLE, pend_target = 0.
  - FLUSH = 0, TAKEN_COUNT = 0.
  - A held redirect is discarded.
  - Reset overrides STALL.

## Timing
- TAKEN and PC_INC are combinational from the inputs and state: same-cycle, no internal delay.
- PC latency is 1 cycle: a decision in cycle n appears on PC in cycle n+1.
- A stalled redirect appears on the first edge where STALL=0.
- FLUSH is high for exactly the one cycle in which PC first shows a redirected target.
- Back-to-back taken branches in consecutive unstalled cycles are legal. FLUSH then stays high on each.
- Output values during reset: PC=RESET_PC, FLUSH=0, REDIRECT_PENDING=0, TAKEN_COUNT=0.

## Structure
- Shared package cpu_pkg:
  - INSTR_BYTES = 4 and WORD_SHIFT = 2
  - State enum {IDLE, PENDING}
- Sub-module branch_offset_gen: combinational; sign-extends and shifts OFFSET to PC_W.
- Top level holds:
  - take logic
  - target adder
  - PC register, state and pend_target registers
  - FLUSH flop and counter

## Test plan
- Reset with PC_W=32, RESET_PC=0x100:
  - Hold RESET=0 two cycles, then release; 3 unstalled cycles, no strobes.
  - Required: PC = 0x100, 0x104, 0x108, 0x10C; FLUSH=0 throughout.
- BEQ taken vs. not taken, PC=0x40, OFFSET=8'hFE (-2):
  - BEQ with ZERO=1: TAKEN=1 and PC_INC=0xFFFFFFF8 that cycle; next PC=0x3C with FLUSH=1.
  - Repeat with ZERO=0: next PC=0x44, FLUSH=0.
- BNE and BLT taken:
  - BNE, ZERO=0, OFFSET=3 from PC=0x20: next PC=0x30.
  - BLT, NEG=1, OFFSET=1 from PC=0x30: next PC=0x38.
  - Required: TAKEN_COUNT=2.
- Stall with redirect, PC=0x80:
  - STALL=1 with J and OFFSET=4; keep STALL 3 cycles while toggling J/BEQ/OFFSET.
  - Required: PC stays 0x80, REDIRECT_PENDING=1, TAKEN_COUNT incremented once.
  - On release: PC=0x94 and FLUSH=1 for one cycle.
- Wrap-around and reset mid-pending:
  - J with OFFSET=1 at PC=0xFFFFFFF8: next PC=0x00000000.
  - Enter PENDING, then assert RESET=0 while STALL=1.
  - Required: PC=RESET_PC, REDIRECT_PENDING=0, no FLUSH after release.
- Counter saturation, CNT_W=2:
  - Five consecutive taken jumps.
  - Required: TAKEN_COUNT = 1, 2, 3, 3, 3.
